// File: rtl/tmds_decode_align.sv
// TMDS receive lane: word alignment via deserializer bitslip plus character decode.
// Ports:
//   pixel_clk   - character clock, all logic on rising edge
//   resetn      - async active-low reset (released synchronously inside)
//   tmds_data   - raw 10-bit character from the 1:10 deserializer, bit 0 first on wire
//   pdata       - decoded data byte, valid when active=1
//   ctl         - decoded control value {C1,C0}, valid when active=0
//   active      - output character is a data character
//   aligned     - lane is locked
//   bitslip     - one-cycle request to shift the deserializer by one bit
//   slip_count  - bitslips since the last lock, wraps 9 -> 0
module tmds_decode_align #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned SLIP_WAIT     = 16,
  parameter int unsigned LOSS_TIMEOUT  = 4096
) (
  input  logic       pixel_clk,
  input  logic       resetn,
  input  logic [9:0] tmds_data,
  output logic [7:0] pdata,
  output logic [1:0] ctl,
  output logic       active,
  output logic       aligned,
  output logic       bitslip,
  output logic [3:0] slip_count
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned RUN_W  = 4;
  localparam int unsigned SLIP_W = 4;

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'(SEARCH_WINDOW - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SLIP_WAIT - 1);
  localparam logic [CNT_W-1:0]  LOSS_LAST   = CNT_W'(LOSS_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK    = RUN_W'(CTRL_RUN);
  localparam logic [SLIP_W-1:0] SLIP_WRAP   = SLIP_W'(9);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_e;

  // Reset synchronizer: assertion is immediate, release waits two clock edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [9:0]        s1_q, s1_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [7:0]        pdata_q, pdata_d;
  logic [1:0]        ctl_q, ctl_d;
  logic              active_q, active_d;
  logic              aligned_q, aligned_d;
  logic              bitslip_q, bitslip_d;

  logic              tok_hit;
  logic [1:0]        tok_ctl;
  logic [7:0]        d_word;
  logic [7:0]        dec_byte;

  always_comb s1_d = tmds_data;

  // Control-token match on the stage-1 character.
  always_comb begin
    tok_hit = 1'b1;
    tok_ctl = 2'b00;
    case (s1_q)
      10'b1101010100: tok_ctl = 2'b00;
      10'b0010101011: tok_ctl = 2'b01;
      10'b0101010100: tok_ctl = 2'b10;
      10'b1010101011: tok_ctl = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
  end

  // Undo the DC-balance inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d_word   = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
    dec_byte = '0;
    dec_byte[0] = d_word[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = s1_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
    end
  end

  // Alignment FSM and its counters; win_cnt doubles as the settle timer.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    loss_cnt_d = loss_cnt_q;
    run_cnt_d  = run_cnt_q;
    slip_cnt_d = slip_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        win_cnt_d = (win_cnt_q == CNT_MAX) ? win_cnt_q : win_cnt_q + CNT_W'(1);
        if (tok_hit) run_cnt_d = (run_cnt_q >= RUN_LOCK) ? RUN_LOCK : run_cnt_q + RUN_W'(1);
        else         run_cnt_d = '0;
        // Lock wins over a window timeout landing on the same cycle.
        if (tok_hit && (run_cnt_d >= RUN_LOCK)) begin
          state_d    = ST_LOCKED;
          loss_cnt_d = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          state_d    = ST_SLIP;
          slip_cnt_d = (slip_cnt_q == SLIP_WRAP) ? '0 : slip_cnt_q + SLIP_W'(1);
        end
      end
      ST_SLIP: begin
        state_d   = ST_SETTLE;
        win_cnt_d = '0;
      end
      ST_SETTLE: begin
        if (win_cnt_q == SETTLE_LAST) begin
          state_d   = ST_SEARCH;
          win_cnt_d = '0;
          run_cnt_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (tok_hit) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q >= LOSS_LAST) begin
          state_d    = ST_SEARCH;
          win_cnt_d  = '0;
          run_cnt_d  = '0;
          loss_cnt_d = '0;
          slip_cnt_d = '0;
        end else begin
          loss_cnt_d = (loss_cnt_q == CNT_MAX) ? loss_cnt_q : loss_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Stage-2 outputs follow the next lock state so data and aligned move together.
  always_comb begin
    aligned_d = (state_d == ST_LOCKED);
    bitslip_d = (state_d == ST_SLIP);
    pdata_d   = '0;
    ctl_d     = '0;
    active_d  = 1'b0;
    if (aligned_d) begin
      if (tok_hit) begin
        ctl_d = tok_ctl;
      end else begin
        active_d = 1'b1;
        pdata_d  = dec_byte;
        ctl_d    = ctl_q;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_SEARCH;
      s1_q       <= '0;
      win_cnt_q  <= '0;
      loss_cnt_q <= '0;
      run_cnt_q  <= '0;
      slip_cnt_q <= '0;
      pdata_q    <= '0;
      ctl_q      <= '0;
      active_q   <= 1'b0;
      aligned_q  <= 1'b0;
      bitslip_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      win_cnt_q  <= win_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      run_cnt_q  <= run_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      pdata_q    <= pdata_d;
      ctl_q      <= ctl_d;
      active_q   <= active_d;
      aligned_q  <= aligned_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign pdata      = pdata_q;
  assign ctl        = ctl_q;
  assign active     = active_q;
  assign aligned    = aligned_q;
  assign bitslip    = bitslip_q;
  assign slip_count = slip_cnt_q;

endmodule

// File: doc/tmds_decode_align.md
# tmds_decode_align

Receive-side counterpart of the HDMI TMDS encoder: takes one 10-bit TMDS character per `pixel_clk` from a per-lane 1:10 deserializer, finds word alignment by driving the deserializer's bitslip, and decodes characters into 8-bit pixel data or 2-bit control values. One instance per lane (three per link). Sits between the lane deserializer and the receive video-timing recovery logic.

## Interface
Parameters:
- `CTRL_RUN`, 8: consecutive control tokens required to declare lock.
- `SEARCH_WINDOW`, 4096: cycles to wait in search before issuing a bitslip.
- `SLIP_WAIT`, 16: settle cycles after a bitslip pulse before searching again.
- `LOSS_TIMEOUT`, 4096: cycles without any control token before dropping lock.

Ports:
- `pixel_clk` in 1: pixel clock; all logic runs on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `tmds_data` in 10: raw character from the deserializer; bit 0 is first on the wire.
- `pdata` out 8: decoded data byte; valid when `active`=1.
- `ctl` out 2: decoded control value {C1,C0}; valid when `active`=0.
- `active` out 1: 1 when the output character is a data character.
- `aligned` out 1: lock status.
- `bitslip` out 1: one-cycle pulse to the deserializer requesting a one-bit shift.
- `slip_count` out 4: bitslips since the last lock; counts 0..9 and wraps.

## Operation
- Token match (combinational on the stage-1 register):
  - 10'b1101010100 → ctl 00
  - 10'b0010101011 → ctl 01
  - 10'b0101010100 → ctl 10
  - 10'b1010101011 → ctl 11
  - Any other value is a data character.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0]
  - out[0] = d[0]
  - for i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Output policy:
  - On a data character: `ctl` holds its last value.
  - On a token: `pdata` is 0.
  - While `aligned`=0: `active`=0, `pdata`=0, `ctl`=00, regardless of input.
- FSM states: SEARCH, SLIP, SETTLE, LOCKED.
- SEARCH:
  - `run_cnt` counts consecutive tokens and clears on any data character.
  - `win_cnt` increments every cycle.
  - When `run_cnt` reaches CTRL_RUN: go to LOCKED. Takes priority over the window timeout in the same cycle.
  - Otherwise, when `win_cnt` = SEARCH_WINDOW-1: go to SLIP.
- SLIP:
  - Asserts `bitslip` for exactly one cycle.
  - Increments `slip_count` (9 wraps to 0).
  - Goes to SETTLE.
- SETTLE:
  - Waits SLIP_WAIT cycles, ignoring input.
  - Then goes to SEARCH with `run_cnt` and `win_cnt` cleared.
- LOCKED:
  - `aligned`=1.
  - `slip_count` is frozen, then cleared on entry to the next SEARCH.
  - `loss_cnt` clears on every token and increments otherwise.
  - At LOSS_TIMEOUT-1 with no token: go to SEARCH. `aligned` falls and outputs are forced as above from the next cycle.
- Counters: `win_cnt` and `loss_cnt` are 13 bits and saturate; `run_cnt` is 4 bits and saturates at CTRL_RUN.
- Reset (async assert, synchronous release):
  - State SEARCH; all counters 0.
  - `pdata`=0, `ctl`=00, `active`=0, `aligned`=0, `bitslip`=0, `slip_count`=0.
  - Reset mid-SLIP or mid-SETTLE abandons the operation; no further `bitslip` pulse is issued.

## Timing
- Pipeline:
  - Stage 1 registers `tmds_data`.
  - Stage 2 registers `pdata`, `ctl`, `active`.
  - Latency from `tmds_data` to the decoded outputs is 2 cycles.
- `aligned` changes in the same cycle the FSM state changes. The lock decision is taken on stage-1 data, so `aligned` rises coincident with the stage-2 output of the CTRL_RUN-th token.
- `bitslip` asserts exactly 1 cycle per SLIP entry.
- Minimum interval between two `bitslip` pulses is 1 + SLIP_WAIT + SEARCH_WINDOW cycles.
- Throughput: one character per cycle, no stalls, no backpressure.

## Test plan
- **Decode sweep:** lock with 8× 10'b1101010100, then feed all 256 encoder outputs with random disparity → `pdata` equals the source byte 2 cycles later, `active`=1.
- **Control tokens:** aligned, then feed the 4 tokens → `ctl` = 00, 01, 10, 11 at 2-cycle latency; `active`=0; `pdata`=0.
- **Bitslip search:** behavioral deserializer misaligned by 3 bits, link in blanking → exactly 3 `bitslip` pulses spaced 4113 cycles apart, then `aligned`=1 and `slip_count`=3.
- **Lock threshold:** 7 tokens then 1 data character, repeated → `aligned` stays 0. Then 8 tokens → `aligned`=1 on the 8th token's output cycle.
- **Loss:** aligned, then 4096 consecutive data characters → `aligned` drops on cycle 4096; `active`/`pdata` forced to 0 from the next cycle.
- **Reset mid-operation:** assert `resetn`=0 during SETTLE → all outputs 0 asynchronously. After release, the next `bitslip` comes no earlier than 4097 cycles later (SEARCH_WINDOW + 1 SLIP cycle).
